// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two combinational read ports, one synchronous write port
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:1]      write_sel;
    logic [DATA_WIDTH-1:0] entries [DEPTH];

    // One-hot write decoder; entry 0 has no enable so writes to it vanish.
    always_comb begin
        write_sel = '0;
        for (int k = 1; k < DEPTH; k++) begin
            write_sel[k] = RegWrite && (WriteRegister == ADDR_WIDTH'(k));
        end
    end

    assign entries[0] = '0;

    genvar i;
    generate
        for (i = 1; i < DEPTH; i++) begin : g_reg
            logic [DATA_WIDTH-1:0] q;

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    q <= '0;
                end else if (write_sel[i]) begin
                    q <= WriteData;
                end
            end

            assign entries[i] = q;
        end
    endgenerate

    // No write-to-read bypass: a same-cycle write shows up only after the edge.
    assign ReadData1 = entries[ReadRegister1];
    assign ReadData2 = entries[ReadRegister2];

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file
module tb_register_file;
    logic        Clk;
    logic        Rst_n;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int checks   = 0;
    int failures = 0;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] mdl [32];

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd,
                                logic [4:0] r1, logic [4:0] r2,
                                logic [31:0] e1, logic [31:0] e2);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
    endtask

    initial begin
        Rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
        #2 Rst_n = 1'b0;
        #1;
        check("reset_rd1", ReadData1, 32'd0);
        check("reset_rd2", ReadData2, 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Test-plan sequences as a vector table; expectations are post-edge reads.
        vecs.push_back(mk(1, 5'd2,  32'd42, 5'd2,  5'd2,  32'd42, 32'd42));
        vecs.push_back(mk(1, 5'd2,  32'd15, 5'd2,  5'd2,  32'd15, 32'd15));
        vecs.push_back(mk(0, 5'd2,  32'd8,  5'd2,  5'd2,  32'd15, 32'd15));
        vecs.push_back(mk(1, 5'd2,  32'd8,  5'd10, 5'd10, 32'd0,  32'd0));
        vecs.push_back(mk(0, 5'd0,  32'd0,  5'd2,  5'd2,  32'd8,  32'd8));
        vecs.push_back(mk(1, 5'd0,  32'd8,  5'd0,  5'd0,  32'd0,  32'd0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 5'(i), 32'(i), 5'(i), 5'(i), 32'(i), 32'(i)));
        vecs.push_back(mk(0, 5'd3,  32'hFFFF_FFFF, 5'd3, 5'd4, 32'd3, 32'd4));
        vecs.push_back(mk(1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd1, 32'hCAFE_F00D, 32'd1));

        foreach (vecs[k]) begin
            @(negedge Clk);
            drive(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].r1, vecs[k].r2);
            @(posedge Clk);
            #1;
            check($sformatf("vec%0d_rd1", k), ReadData1, vecs[k].e1);
            check($sformatf("vec%0d_rd2", k), ReadData2, vecs[k].e2);
        end

        // Same-address read and write: old value before the edge, new after.
        @(negedge Clk);
        drive(1'b1, 5'd7, 32'h0000_A5A5, 5'd7, 5'd7);
        #1;
        check("rw_same_pre_rd1", ReadData1, 32'd0);
        check("rw_same_pre_rd2", ReadData2, 32'd0);
        @(posedge Clk);
        #1;
        check("rw_same_post_rd1", ReadData1, 32'h0000_A5A5);
        check("rw_same_post_rd2", ReadData2, 32'h0000_A5A5);

        // Asynchronous reset between edges, then a write blocked by reset.
        @(negedge Clk);
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd2);
        @(posedge Clk);
        #1;
        check("r5_loaded", ReadData1, 32'hDEAD_BEEF);
        RegWrite = 1'b0;
        #1 Rst_n = 1'b0;
        #1;
        check("async_rst_r5", ReadData1, 32'd0);
        check("async_rst_r2", ReadData2, 32'd0);
        @(negedge Clk);
        drive(1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd7);
        @(posedge Clk);
        #1;
        check("write_in_rst_r5", ReadData1, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        RegWrite = 1'b0;
        #1;
        check("after_rst_r5", ReadData1, 32'd0);
        check("after_rst_r7", ReadData2, 32'd0);

        // Randomized traffic against an array model of the register contents.
        for (int a = 0; a < 32; a++) mdl[a] = 32'd0;
        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic [4:0]  wa, r1, r2;
            logic [31:0] wd;
            @(negedge Clk);
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(we, wa, wd, r1, r2);
            #1;
            check("rand_pre_rd1", ReadData1, mdl[r1]);
            check("rand_pre_rd2", ReadData2, mdl[r2]);
            @(posedge Clk);
            if (we && wa != 5'd0) mdl[wa] = wd;
            #1;
            check("rand_post_rd1", ReadData1, mdl[r1]);
            check("rand_post_rd2", ReadData2, mdl[r2]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
